alu_mdu: RTL

Parametrised, handshaked execution unit that replaces the single-cycle combinational ALU in the RV32I datapath. It covers the full base integer operation set, with a registered result and a valid/ready interface. It adds an iterative multiply/divide unit for the M extension, so the core can stall on a busy execute stage instead of timing a combinational multiplier. The unit sits between operand fetch/forwarding and writeback.

---
 rtl/alu_mdu_if.sv | 28 ++
 rtl/alu_mdu.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_if.sv
// Request/result bundle for alu_mdu: operand handshake, result handshake and status.
interface alu_mdu_if #(
  parameter int XLEN = 32
);
  // Handshake: a transfer happens on a rising clk edge where valid && ready are both high;
  // valid never waits on ready, and a source holds its payload while valid && !ready.
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out;
  logic            zero;
  logic            busy;
  logic [1:0]      dbg_state;

  modport master (
    output in_valid, op, in1, in2, out_ready,
    input  in_ready, out_valid, out, zero, busy, dbg_state
  );

  modport slave (
    input  in_valid, op, in1, in2, out_ready,
    output in_ready, out_valid, out, zero, busy, dbg_state
  );
endinterface

// File: rtl/alu_mdu.sv
// RV32I ALU with registered, handshaked result plus an iterative RISC-V M multiply/divide unit.
// The M datapath (ITER/FIX states, busy) is compiled in only when ALU_MDU_M_EN is defined.
module alu_mdu #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  alu_mdu_if.slave bus
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          state_q;
  logic            out_valid_q;
  logic            zero_q;
  logic [XLEN-1:0] out_q;
  logic            in_ready;
  logic            accept;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] base_res;

  assign shamt    = bus.in2[SW-1:0];
  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Unknown codes, including every op[4]=1 code when M is absent, resolve to zero.
  always_comb begin
    base_res = '0;
    case (bus.op)
      5'b00000: base_res = bus.in1 & bus.in2;
      5'b00001: base_res = bus.in1 | bus.in2;
      5'b00010: base_res = bus.in1 + bus.in2;
      5'b00110: base_res = bus.in1 - bus.in2;
      5'b00101: base_res = bus.in1 ^ bus.in2;
      5'b01010: base_res = bus.in1 << shamt;
      5'b01000: base_res = bus.in1 >> shamt;
      5'b01001: base_res = $signed(bus.in1) >>> shamt;
      5'b01100: base_res = {{(XLEN-1){1'b0}}, ($signed(bus.in1) < $signed(bus.in2))};
      5'b01101: base_res = {{(XLEN-1){1'b0}}, (bus.in1 < bus.in2)};
      default:  base_res = '0;
    endcase
  end

`ifdef ALU_MDU_M_EN
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic [XLEN-1:0]   b_q;
  logic [2:0]        mop_q;
  logic              qneg_q;
  logic              rneg_q;
  logic              is_m;
  logic              sgn1, sgn2, s1, s2;
  logic [XLEN-1:0]   mag1, mag2;
  logic [XLEN:0]     sum_w, shifted_w, diff_w;
  logic [XLEN-1:0]   hi_d, lo_d, fix_d;
  logic [2*XLEN-1:0] prod_w;

  assign is_m = bus.op[4] && !bus.op[3];

  // Operands are reduced to magnitudes up front; the sign is reapplied in FIX.
  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    case (bus.op[2:0])
      3'b001, 3'b100, 3'b110: begin
        sgn1 = 1'b1;
        sgn2 = 1'b1;
      end
      3'b010:  sgn1 = 1'b1;
      default: ;
    endcase
    s1   = sgn1 && bus.in1[XLEN-1];
    s2   = sgn2 && bus.in2[XLEN-1];
    mag1 = s1 ? -bus.in1 : bus.in1;
    mag2 = s2 ? -bus.in2 : bus.in2;
  end

  // Multiply: {hi,lo} shifts right, adding the multiplicand when lo[0] is set.
  // Divide: restoring step, dividend bits leave lo's top as quotient bits enter lo's bottom.
  always_comb begin
    sum_w     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted_w = {hi_q, lo_q[XLEN-1]};
    diff_w    = shifted_w - {1'b0, b_q};
    if (mop_q[2]) begin
      if (!diff_w[XLEN]) begin
        hi_d = diff_w[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = shifted_w[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_d = sum_w[XLEN:1];
      lo_d = {sum_w[0], lo_q[XLEN-1:1]};
    end
  end

  // Divide by zero leaves quotient all ones and remainder |in1|; qneg_q is cleared for it.
  always_comb begin
    prod_w = {hi_q, lo_q};
    if (qneg_q) prod_w = -prod_w;
    case (mop_q)
      3'b000:                 fix_d = prod_w[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_d = prod_w[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_d = qneg_q ? -lo_q : lo_q;
      default:                fix_d = rneg_q ? -hi_q : hi_q;
    endcase
  end

  assign bus.busy = (state_q != S_IDLE);
`else
  assign bus.busy = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b1;
`ifdef ALU_MDU_M_EN
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      b_q         <= '0;
      mop_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
`ifdef ALU_MDU_M_EN
            if (is_m) begin
              hi_q    <= '0;
              lo_q    <= bus.op[2] ? mag1 : mag2;
              b_q     <= bus.op[2] ? mag2 : mag1;
              mop_q   <= bus.op[2:0];
              qneg_q  <= (s1 ^ s2) && !(bus.op[2] && (bus.in2 == '0));
              rneg_q  <= s1;
              cnt_q   <= CW'(XLEN);
              state_q <= S_ITER;
            end else
`endif
            begin
              out_q       <= base_res;
              zero_q      <= (base_res == '0);
              out_valid_q <= 1'b1;
            end
          end
        end
`ifdef ALU_MDU_M_EN
        S_ITER: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          out_q       <= fix_d;
          zero_q      <= (fix_d == '0);
          out_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.dbg_state = state_q;
endmodule
